// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C-style controller:
// FSM state encoding, quarter-slot indices and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_RW    = 3'd3,
    S_AACK  = 3'd4,
    S_DATA  = 3'd5,
    S_DACK  = 3'd6,
    S_STOP  = 3'd7
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_master_ctrl_qtick.sv
// Quarter-period timebase: a CLK_DIV down-counter producing a one-cycle
// tick at the end of each quarter, plus a 2-bit quarter index Q0..Q3.
// Held at the start of Q0 while clr is asserted (controller idle).
module i2c_qtick #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);
  import i2c_pkg::*;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_reg;

  assign tick = (div_reg == 8'd0) && !clr;

  // Down-counter reloads on every quarter boundary; quarter index wraps mod 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= RELOAD;
      quarter <= Q0;
    end else if (clr) begin
      div_reg <= RELOAD;
      quarter <= Q0;
    end else if (div_reg == 8'd0) begin
      div_reg <= RELOAD;
      quarter <= quarter + 2'd1;
    end else begin
      div_reg <= div_reg - 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C-style controller: START, address, R/W, address ACK,
// data, data ACK/NACK, STOP. SCL is push-pull, SDA is open-drain emulated
// through sda_oe (1 = pull low). Every bit slot is four quarters.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 6,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic              scl_out,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe
);

  localparam int CNT_W = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

  state_t            state, state_next;
  logic              tick;
  logic [1:0]        quarter;
  logic              slot_end, sample_pt, drive_pt;
  logic              rw_reg, sda_smp;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] wdata_sh, shadow;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sda_oe_reg, sda_oe_next;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_IDLE),
    .tick    (tick),
    .quarter (quarter)
  );

  assign slot_end  = tick && (quarter == Q3);
  assign sample_pt = tick && (quarter == Q2);
  assign drive_pt  = tick && (quarter == Q0);

  // Idle and START hold SCL high; data and STOP slots are low in Q0-Q1, high in Q2-Q3.
  assign scl_out = (state == S_IDLE || state == S_START) ? 1'b1 : (quarter >= Q2);
  assign busy    = (state != S_IDLE);
  assign sda_out = 1'b0;
  assign sda_oe  = sda_oe_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and SDA drive decode; SDA data bits change at the Q0->Q1 boundary.
  always_comb begin
    state_next  = state;
    sda_oe_next = sda_oe_reg;
    case (state)
      S_IDLE: begin
        sda_oe_next = 1'b0;
        if (start) state_next = S_START;
      end
      S_START: begin
        if (tick && quarter == Q1) sda_oe_next = 1'b1;
        if (slot_end) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (drive_pt) sda_oe_next = ~addr_sh[ADDR_W-1];
        if (slot_end && bit_cnt == '0) state_next = S_RW;
      end
      S_RW: begin
        if (drive_pt) sda_oe_next = ~rw_reg;
        if (slot_end) state_next = S_AACK;
      end
      S_AACK: begin
        if (drive_pt) sda_oe_next = 1'b0;
        if (slot_end) state_next = (sda_smp == ACK) ? S_DATA : S_STOP;
      end
      S_DATA: begin
        if (drive_pt) sda_oe_next = rw_reg ? 1'b0 : ~wdata_sh[DATA_W-1];
        if (slot_end && bit_cnt == '0) state_next = S_DACK;
      end
      S_DACK: begin
        if (drive_pt) sda_oe_next = 1'b0;
        if (slot_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (tick && quarter == Q2) sda_oe_next = 1'b0;
        if (slot_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // STOP pulls SDA low from its first quarter so the Q3 release is a rising edge under high SCL.
    if (slot_end && state != S_STOP && state_next == S_STOP) sda_oe_next = 1'b1;
  end

  // SDA drive register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sda_oe_reg <= 1'b0;
    else        sda_oe_reg <= sda_oe_next;
  end

  // Request capture, SDA sampling, shift registers, bit counter and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_reg   <= 1'b0;
      addr_sh  <= '0;
      wdata_sh <= '0;
      shadow   <= '0;
      bit_cnt  <= '0;
      sda_smp  <= 1'b1;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        rw_reg   <= rw;
        addr_sh  <= addr;
        wdata_sh <= wdata;
        shadow   <= '0;
        ack_err  <= 1'b0;
      end
      if (sample_pt) sda_smp <= sda_in;
      if (sample_pt && state == S_DATA && rw_reg) shadow <= {shadow[DATA_W-2:0], sda_in};
      if (slot_end) begin
        case (state)
          S_START: bit_cnt <= CNT_W'(ADDR_W - 1);
          S_ADDR: begin
            addr_sh <= addr_sh << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
          S_AACK: begin
            if (sda_smp == NACK) ack_err <= 1'b1;
            bit_cnt <= CNT_W'(DATA_W - 1);
          end
          S_DATA: begin
            wdata_sh <= wdata_sh << 1;
            bit_cnt  <= bit_cnt - 1'b1;
          end
          S_DACK: if (!rw_reg && sda_smp == NACK) ack_err <= 1'b1;
          S_STOP: begin
            done <= 1'b1;
            if (rw_reg && !ack_err) rdata <= shadow;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural open-drain responder.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] addr = '0;
  logic [5:0] wdata = '0;
  logic [5:0] rdata;
  logic       busy, done, ack_err, scl_out, sda_out, sda_oe;
  logic       resp_pull = 1'b0;
  logic       sda_line;

  // Responder configuration (written only by the stimulus block)
  logic       resp_en = 1'b0;
  logic       resp_rd = 1'b0;
  logic       resp_data_ack = 1'b1;
  logic [5:0] resp_data = '0;

  // Bus monitor state (written only by the monitor block)
  int          rise_cnt = 0;
  logic [13:0] cap = '0;
  int          hi_fall = 0;
  int          hi_rise = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;

  int checks = 0;
  int failures = 0;

  assign sda_line = ~(sda_oe | resp_pull);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.ADDR_W(4), .DATA_W(6), .CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_out (scl_out),
    .sda_in  (sda_line),
    .sda_out (sda_out),
    .sda_oe  (sda_oe)
  );

  // Monitor + responder: tracks START/STOP edges, captures SDA at SCL rises,
  // and sets the responder pull just after each SCL fall.
  always @(negedge clk) begin
    logic sda_now;
    logic pull_n;
    int   slot;
    sda_now = ~(sda_oe | resp_pull);
    pull_n  = resp_pull;
    if (prev_scl && scl_out && prev_sda && !sda_now) begin
      hi_fall  <= hi_fall + 1;
      rise_cnt <= 0;
      cap      <= '0;
    end
    if (prev_scl && scl_out && !prev_sda && sda_now) hi_rise <= hi_rise + 1;
    if (!prev_scl && scl_out) begin
      rise_cnt <= rise_cnt + 1;
      cap      <= {cap[12:0], sda_now};
    end
    if (prev_scl && !scl_out) begin
      slot   = rise_cnt + 1;
      pull_n = 1'b0;
      if (resp_en) begin
        if (slot == 6) pull_n = 1'b1;
        else if (slot >= 7 && slot <= 12 && resp_rd) pull_n = ~resp_data[12-slot];
        else if (slot == 13 && !resp_rd) pull_n = resp_data_ack;
      end
    end
    resp_pull <= pull_n;
    prev_scl  <= scl_out;
    prev_sda  <= ~(sda_oe | pull_n);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame for 300 cycles after the start edge; k counts negedges after it.
  task automatic frame(input logic f_rw, input logic [3:0] f_addr, input logic [5:0] f_wdata,
                       input int inject, output int done_at, output int done_cnt,
                       output int busy_bad, output logic [5:0] rdata_at_done);
    rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = 0; done_cnt = 0; busy_bad = 0; rdata_at_done = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == inject) begin
        start = 1'b1; rw = ~f_rw; addr = ~f_addr;
      end else if (k == inject + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          rdata_at_done = rdata;
        end
      end
      if (done_at == 0 && !done && !busy) busy_bad++;
      if (done && busy) busy_bad++;
    end
  endtask

  initial begin
    int d_at, d_cnt, b_bad, f0, r0;
    logic [5:0] rd_at;

    // Reset state, including start asserted during reset
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_out, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_sda_out", sda_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rdata", rdata, 6'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Frame 1: write, both ACKed
    resp_en = 1'b1; resp_rd = 1'b0; resp_data_ack = 1'b1;
    f0 = hi_fall; r0 = hi_rise;
    frame(1'b0, 4'b0010, 6'b101101, -1, d_at, d_cnt, b_bad, rd_at);
    $display("frame 1 write: done_at=%0d done_cnt=%0d ack_err=%0b bits=%b", d_at, d_cnt, ack_err, cap);
    chk("w1_done_at", d_at, 241);
    chk("w1_done_cnt", d_cnt, 1);
    chk("w1_busy", b_bad, 0);
    chk("w1_ack_err", ack_err, 1'b0);
    chk("w1_rises", rise_cnt, 14);
    chk("w1_bits", cap, 14'b00100010110100);
    chk("w1_start_edges", hi_fall - f0, 1);
    chk("w1_stop_edges", hi_rise - r0, 1);
    chk("w1_rdata", rdata, 6'd0);

    // Frame 2: read, responder returns 010011
    resp_rd = 1'b1; resp_data = 6'b010011;
    frame(1'b1, 4'b0010, 6'b000000, -1, d_at, d_cnt, b_bad, rd_at);
    $display("frame 2 read: done_at=%0d rdata=%b ack_err=%0b bits=%b", d_at, rd_at, ack_err, cap);
    chk("r2_done_at", d_at, 241);
    chk("r2_rdata_done", rd_at, 6'b010011);
    chk("r2_ack_err", ack_err, 1'b0);
    chk("r2_bits", cap, 14'b00101001001110);
    chk("r2_busy", b_bad, 0);

    // Frame 3: address NACK
    resp_en = 1'b0;
    f0 = hi_fall; r0 = hi_rise;
    frame(1'b1, 4'b0010, 6'b000000, -1, d_at, d_cnt, b_bad, rd_at);
    $display("frame 3 addr-nack: done_at=%0d rdata=%b ack_err=%0b bits=%b", d_at, rdata, ack_err, cap);
    chk("n3_done_at", d_at, 129);
    chk("n3_done_cnt", d_cnt, 1);
    chk("n3_ack_err", ack_err, 1'b1);
    chk("n3_rdata", rdata, 6'b010011);
    chk("n3_rises", rise_cnt, 7);
    chk("n3_bits", cap, 14'b00000000010110);
    chk("n3_stop_edges", hi_rise - r0, 1);
    chk("n3_busy", b_bad, 0);

    // Frame 4: write with data NACK
    resp_en = 1'b1; resp_rd = 1'b0; resp_data_ack = 1'b0;
    frame(1'b0, 4'b0010, 6'b101101, -1, d_at, d_cnt, b_bad, rd_at);
    $display("frame 4 data-nack: done_at=%0d ack_err=%0b bits=%b", d_at, ack_err, cap);
    chk("d4_done_at", d_at, 241);
    chk("d4_ack_err", ack_err, 1'b1);
    chk("d4_bits", cap, 14'b00100010110110);
    chk("d4_rdata", rdata, 6'b010011);

    // Frame 5: good write, start re-pulsed at k=50 while busy
    resp_data_ack = 1'b1;
    f0 = hi_fall; r0 = hi_rise;
    frame(1'b0, 4'b0010, 6'b110010, 50, d_at, d_cnt, b_bad, rd_at);
    $display("frame 5 write+busy-start: done_at=%0d done_cnt=%0d ack_err=%0b bits=%b", d_at, d_cnt, ack_err, cap);
    chk("w5_done_at", d_at, 241);
    chk("w5_done_cnt", d_cnt, 1);
    chk("w5_ack_err", ack_err, 1'b0);
    chk("w5_bits", cap, 14'b00100011001000);
    chk("w5_start_edges", hi_fall - f0, 1);
    chk("w5_stop_edges", hi_rise - r0, 1);
    chk("w5_busy", b_bad, 0);

    // Frame 6: reset asserted in DATA slot (bit4 of 101101 driven low)
    rw = 1'b0; addr = 4'b0010; wdata = 6'b101101; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (134) @(negedge clk);
    chk("x6_pre_scl", scl_out, 1'b0);
    chk("x6_pre_sda_oe", sda_oe, 1'b1);
    chk("x6_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    $display("frame 6 reset mid-data: scl=%0b sda_oe=%0b busy=%0b", scl_out, sda_oe, busy);
    chk("x6_scl", scl_out, 1'b1);
    chk("x6_sda_oe", sda_oe, 1'b0);
    chk("x6_busy", busy, 1'b0);
    chk("x6_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("x6_rdata_cleared", rdata, 6'd0);

    // Frame 7: normal write after reset
    frame(1'b0, 4'b0010, 6'b101101, -1, d_at, d_cnt, b_bad, rd_at);
    $display("frame 7 write after reset: done_at=%0d ack_err=%0b bits=%b", d_at, ack_err, cap);
    chk("w7_done_at", d_at, 241);
    chk("w7_ack_err", ack_err, 1'b0);
    chk("w7_bits", cap, 14'b00100010110100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
